// File: rtl/rc_req_arbiter_if.sv
// rtl/rc_req_arbiter_if.sv - requester/resource-controller channel bundle for rc_req_arbiter
interface rc_req_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         req_n;
    logic [NREQ-1:0]         ack_n;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    busy;
    logic                    rc_reqn;
    logic                    rc_ackn;
    logic                    wdog_err;

    modport master (
        output req_n,
        output rc_ackn,
        input  ack_n,
        input  grant_id,
        input  busy,
        input  rc_reqn,
        input  wdog_err
    );

    modport slave (
        input  req_n,
        input  rc_ackn,
        output ack_n,
        output grant_id,
        output busy,
        output rc_reqn,
        output wdog_err
    );
endinterface

// File: rtl/rc_req_arbiter.sv
// rtl/rc_req_arbiter.sv - round-robin arbiter sharing one rc_reqn/rc_ackn channel; watchdog under RC_ARB_WDOG_EN
module rc_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rstn,
    rc_req_arbiter_if.slave  bus
);
    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rc_reqn_q, rc_reqn_d;
    logic [NREQ-1:0]   ack_n_q, ack_n_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic              busy_q, busy_d;

    logic              any_req;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     idx_g;
    int                idx;

    // Search starts just above the last winner and wraps, so priority rotates.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        idx_g   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(last_q) + k) % NREQ;
            idx_g = GW'(idx);
            if (!any_req && !bus.req_n[idx_g]) begin
                any_req = 1'b1;
                winner  = idx_g;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rc_reqn_q <= 1'b1;
            ack_n_q   <= '1;
            grant_q   <= '0;
            last_q    <= GW'(NREQ - 1);
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_reqn_q <= rc_reqn_d;
            ack_n_q   <= ack_n_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rc_reqn_d = rc_reqn_q;
        ack_n_d   = ack_n_q;
        grant_d   = grant_q;
        last_d    = last_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d   = winner;
                    rc_reqn_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                rc_reqn_d = 1'b0;
                if (!bus.rc_ackn) begin
                    rc_reqn_d = 1'b1;
                    ack_n_d   = ~(NREQ'(1) << grant_q);
                    state_d   = DONE;
                end
            end
            DONE: begin
                last_d  = grant_q;
                ack_n_d = '1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rc_reqn  = rc_reqn_q;
    assign bus.ack_n    = ack_n_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;

`ifdef RC_ARB_WDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wdog_err_q, wdog_err_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wd_cnt_q   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    // Error flags on the edge where the count reaches TIMEOUT; the count then saturates.
    always_comb begin
        wd_cnt_d   = wd_cnt_q;
        wdog_err_d = wdog_err_q;
        if (state_q == IDLE && any_req) begin
            wd_cnt_d = '0;
        end else if (state_q == REQ) begin
            if (wd_cnt_q != CW'(TIMEOUT)) begin
                wd_cnt_d = wd_cnt_q + CW'(1);
            end
            if (wd_cnt_q >= CW'(TIMEOUT - 1)) begin
                wdog_err_d = 1'b1;
            end
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign bus.wdog_err = 1'b0;
`endif
endmodule
